// File: rtl/multicycle_datapath_pkg.sv
// Shared encodings for the multicycle CPU datapath and its control FSM.
//  - ALU B-input select codes (ALU2) and ALU operation codes (ALUop)
//  - IR field bit positions
package multicycle_datapath_pkg;

  typedef enum logic [2:0] {
    ALU2_OPB  = 3'b000,
    ALU2_ONE  = 3'b001,
    ALU2_IMM4 = 3'b010,
    ALU2_IMM5 = 3'b011,
    ALU2_IMM3 = 3'b100,
    ALU2_ZERO = 3'b101
  } alu2_sel_e;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_SUB   = 3'b001,
    ALUOP_OR    = 3'b010,
    ALUOP_NAND  = 3'b011,
    ALUOP_SHIFT = 3'b100
  } alu_op_e;

  localparam int unsigned IR_RA_HI   = 7;
  localparam int unsigned IR_RA_LO   = 6;
  localparam int unsigned IR_RB_HI   = 5;
  localparam int unsigned IR_RB_LO   = 4;
  localparam int unsigned IR_IMM4_LO = 4;
  localparam int unsigned IR_IMM5_LO = 3;
  localparam int unsigned IR_IMM3_HI = 6;
  localparam int unsigned IR_SHDIR   = 3;

endpackage

// File: rtl/multicycle_datapath_regfile.sv
// cpu_regfile: 4 x DATA_W register file.
//  clock, reset   : clock, asynchronous active-high reset (clears all registers)
//  raddr_a/rdata_a: asynchronous read port A
//  raddr_b/rdata_b: asynchronous read port B
//  we/waddr/wdata : synchronous write port
module cpu_regfile #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [4];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads are combinational, so a same-cycle write is seen only after the edge.
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: datapath of the multicycle simple CPU.
//  Holds PC, IR, MDR, register file, OpA/OpB, ALUout, ALU and N/Z flags.
//  Inputs : clock, reset, control strobes from the FSM, mem_rdata (async read)
//  Outputs: instr (IR[3:0]), N, Z, mem_addr, mem_wdata, mem_rd, mem_we
module multicycle_datapath
  import multicycle_datapath_pkg::*;
#(
  parameter int unsigned          DATA_W   = 8,
  parameter logic [DATA_W-1:0]    PC_RESET = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              PCwrite,
  input  logic              AddrSel,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IRload,
  input  logic              OpASel,
  input  logic              MDRload,
  input  logic              OpABLoad,
  input  logic              ALU1,
  input  logic [2:0]        ALU2,
  input  logic [2:0]        ALUop,
  input  logic              ALUOutWrite,
  input  logic              RFWrite,
  input  logic              RegIn,
  input  logic              FlagWrite,
  output logic [3:0]        instr,
  output logic              N,
  output logic              Z,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [DATA_W-1:0] pc, ir, mdr, opa, opb, aluout;
  logic [DATA_W-1:0] rf_a, rf_b, rf_wdata;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [1:0]        addr_a;

  assign addr_a   = OpASel ? 2'd1 : ir[IR_RA_HI:IR_RA_LO];
  assign rf_wdata = RegIn ? mdr : aluout;

  cpu_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .raddr_a (addr_a),
    .rdata_a (rf_a),
    .raddr_b (ir[IR_RB_HI:IR_RB_LO]),
    .rdata_b (rf_b),
    .we      (RFWrite),
    .waddr   (addr_a),
    .wdata   (rf_wdata)
  );

  assign alu_a = ALU1 ? opa : pc;

  always_comb begin
    alu_b = '0;
    case (alu2_sel_e'(ALU2))
      ALU2_OPB:  alu_b = opb;
      ALU2_ONE:  alu_b = DATA_W'(1);
      ALU2_IMM4: alu_b = {{(DATA_W-4){ir[IR_RA_HI]}}, ir[IR_RA_HI:IR_IMM4_LO]};
      ALU2_IMM5: alu_b = {{(DATA_W-5){1'b0}}, ir[IR_RA_HI:IR_IMM5_LO]};
      ALU2_IMM3: alu_b = {{(DATA_W-3){1'b0}}, ir[IR_IMM3_HI:IR_IMM4_LO]};
      default:   alu_b = '0;
    endcase
  end

  always_comb begin
    alu_result = alu_a;
    case (alu_op_e'(ALUop))
      ALUOP_ADD:   alu_result = alu_a + alu_b;
      ALUOP_SUB:   alu_result = alu_a - alu_b;
      ALUOP_OR:    alu_result = alu_a | alu_b;
      ALUOP_NAND:  alu_result = ~(alu_a & alu_b);
      ALUOP_SHIFT: alu_result = ir[IR_SHDIR] ? (alu_a >> alu_b[2:0])
                                             : (alu_a << alu_b[2:0]);
      default:     alu_result = alu_a;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc     <= PC_RESET;
      ir     <= '0;
      mdr    <= '0;
      opa    <= '0;
      opb    <= '0;
      aluout <= '0;
      N      <= 1'b0;
      Z      <= 1'b0;
    end else begin
      if (PCwrite)     pc     <= alu_result;
      if (IRload)      ir     <= mem_rdata;
      if (MDRload)     mdr    <= mem_rdata;
      if (OpABLoad) begin
        opa <= rf_a;
        opb <= rf_b;
      end
      if (ALUOutWrite) aluout <= alu_result;
      if (FlagWrite) begin
        N <= alu_result[DATA_W-1];
        Z <= (alu_result == '0);
      end
    end
  end

  assign instr     = ir[3:0];
  assign mem_addr  = AddrSel ? pc : opb;
  assign mem_wdata = opa;
  assign mem_rd    = MemRead;
  assign mem_we    = MemWrite;

endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;

  logic       clock = 1'b0;
  logic       reset;
  logic       PCwrite, AddrSel, MemRead, MemWrite, IRload, OpASel, MDRload, OpABLoad;
  logic       ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite;
  logic [2:0] ALU2, ALUop;
  logic [3:0] instr;
  logic       N, Z, mem_rd, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];

  multicycle_datapath #(.DATA_W(8), .PC_RESET(8'h00)) dut (
    .clock(clock), .reset(reset), .PCwrite(PCwrite), .AddrSel(AddrSel),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRload(IRload), .OpASel(OpASel),
    .MDRload(MDRload), .OpABLoad(OpABLoad), .ALU1(ALU1), .ALU2(ALU2), .ALUop(ALUop),
    .ALUOutWrite(ALUOutWrite), .RFWrite(RFWrite), .RegIn(RegIn), .FlagWrite(FlagWrite),
    .instr(instr), .N(N), .Z(Z), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  task automatic clr();
    PCwrite = 0; AddrSel = 0; MemRead = 0; MemWrite = 0; IRload = 0; OpASel = 0;
    MDRload = 0; OpABLoad = 0; ALU1 = 0; ALU2 = 3'b000; ALUop = 3'b000;
    ALUOutWrite = 0; RFWrite = 0; RegIn = 0; FlagWrite = 0;
  endtask

  // One clock: the memory model commits a write on the same edge the DUT samples.
  task automatic tick();
    logic       we;
    logic [7:0] a, d;
    we = mem_we; a = mem_addr; d = mem_wdata;
    @(posedge clock);
    if (we) mem[a] = d;
    #1;
    clr();
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_pc(input string tag, input logic [7:0] exp);
    AddrSel = 1; #1;
    check(tag, mem_addr, exp);
    AddrSel = 0; #1;
  endtask

  task automatic load_ir(input logic [7:0] addr, input logic [7:0] v);
    mem[addr] = v; AddrSel = 1; MemRead = 1; IRload = 1; tick();
  endtask

  task automatic opab(input logic sel);
    OpASel = sel; OpABLoad = 1; tick();
  endtask

  task automatic alu(input logic a1, input logic [2:0] a2, input logic [2:0] op,
                     input logic outw, input logic flagw, input logic pcw);
    ALU1 = a1; ALU2 = a2; ALUop = op; ALUOutWrite = outw; FlagWrite = flagw; PCwrite = pcw;
    tick();
  endtask

  task automatic rfwrite(input logic sel, input logic regin);
    OpASel = sel; RFWrite = 1; RegIn = regin; tick();
  endtask

  task automatic read_reg(input string tag, input logic sel, input logic [7:0] exp);
    opab(sel);
    check(tag, mem_wdata, exp);
  endtask

  task automatic inc_reg(input logic sel);
    opab(sel);
    alu(1, 3'b001, 3'b000, 1, 0, 0);
    rfwrite(sel, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    clr();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;

    // Reset state
    check("rst_opb", mem_addr, 8'h00);
    check("rst_instr", {4'h0, instr}, 8'h00);
    check("rst_n", {7'd0, N}, 8'h00);
    check("rst_z", {7'd0, Z}, 8'h00);
    check("rst_opa", mem_wdata, 8'h00);
    check_pc("rst_pc", 8'h00);
    read_reg("rst_r0", 0, 8'h00);
    read_reg("rst_r1", 1, 8'h00);

    // Preload R0=05, R1=03 with increments
    for (int k = 0; k < 5; k++) inc_reg(0);
    for (int k = 0; k < 3; k++) inc_reg(1);

    // add R0 = R0 + R1
    load_ir(8'h00, 8'h14);
    check("ir_instr", {4'h0, instr}, 8'h04);
    opab(0);
    check("add_opa", mem_wdata, 8'h05);
    check("add_opb", mem_addr, 8'h03);
    alu(1, 3'b000, 3'b000, 1, 1, 0);
    rfwrite(0, 0);
    read_reg("add_r0", 0, 8'h08);
    check("add_n", {7'd0, N}, 8'h00);
    check("add_z", {7'd0, Z}, 8'h00);

    // sub R0-R0
    load_ir(8'h00, 8'h00);
    opab(0);
    alu(1, 3'b000, 3'b001, 1, 1, 0);
    check("sub_z", {7'd0, Z}, 8'h01);
    check("sub_n", {7'd0, N}, 8'h00);

    // 0 - 1 = FF, then nand FF,FF = 00
    alu(0, 3'b001, 3'b001, 1, 1, 0);
    check("dec_n", {7'd0, N}, 8'h01);
    check("dec_z", {7'd0, Z}, 8'h00);
    rfwrite(0, 0);
    read_reg("ff_r0", 0, 8'hFF);
    alu(1, 3'b000, 3'b011, 1, 1, 0);
    check("nand_z", {7'd0, Z}, 8'h01);
    check("nand_n", {7'd0, N}, 8'h00);
    rfwrite(1, 0);
    read_reg("nand_r1", 1, 8'h00);

    // Load 81 into R0 through MDR (OpB = R0 = FF)
    mem[8'hFF] = 8'h81;
    MDRload = 1; tick();
    rfwrite(0, 1);
    read_reg("ld81_r0", 0, 8'h81);

    // shift left / right by 1
    alu(1, 3'b001, 3'b100, 1, 0, 0);
    rfwrite(1, 0);
    read_reg("shl_r1", 1, 8'h02);
    load_ir(8'h00, 8'h08);
    opab(0);
    alu(1, 3'b001, 3'b100, 1, 0, 0);
    rfwrite(1, 0);
    read_reg("shr_r1", 1, 8'h40);

    // Fetch: IR from old PC while PC increments
    mem[8'h00] = 8'h14;
    AddrSel = 1; MemRead = 1; IRload = 1; PCwrite = 1; ALU1 = 0; ALU2 = 3'b001; ALUop = 3'b000;
    #1;
    check("fetch_rd", {7'd0, mem_rd}, 8'h01);
    check("fetch_addr", mem_addr, 8'h00);
    tick();
    check("fetch_instr", {4'h0, instr}, 8'h04);
    check_pc("fetch_pc", 8'h01);

    // Load: R1=20 via MDR (OpB currently R0 = 81), then R0 = mem[R1]
    mem[8'h81] = 8'h20;
    MDRload = 1; tick();
    rfwrite(1, 1);
    opab(0);
    check("ld_addr", mem_addr, 8'h20);
    mem[8'h20] = 8'hAB;
    MDRload = 1; tick();
    rfwrite(0, 1);
    read_reg("ld_r0", 0, 8'hAB);

    // Store: mem[R1] <= R0
    mem[8'h20] = 8'h00;
    MemWrite = 1; #1;
    check("st_we", {7'd0, mem_we}, 8'h01);
    tick();
    check("st_mem", mem[8'h20], 8'hAB);

    // Branch: PC 01 + Imm5 0F = 10, then 10 + sext(E) = 0E
    load_ir(8'h01, 8'h78);
    alu(0, 3'b011, 3'b000, 0, 0, 1);
    check_pc("pc_10", 8'h10);
    load_ir(8'h10, 8'hE0);
    alu(0, 3'b010, 3'b000, 0, 0, 1);
    check_pc("br_back", 8'h0E);

    // PC = FF via OpA, then wrap to 00
    load_ir(8'h0E, 8'h78);
    alu(0, 3'b011, 3'b001, 1, 0, 0);
    rfwrite(0, 0);
    opab(0);
    alu(1, 3'b101, 3'b000, 0, 1, 1);
    check_pc("pc_ff", 8'hFF);
    check("pc_ff_n", {7'd0, N}, 8'h01);
    alu(0, 3'b001, 3'b000, 0, 1, 1);
    check_pc("pc_wrap", 8'h00);
    check("wrap_z", {7'd0, Z}, 8'h01);
    check("wrap_n", {7'd0, N}, 8'h00);

    // Reset mid-instruction with strobes active
    reset = 1;
    for (int k = 0; k < 2; k++) begin
      AddrSel = 1; MemRead = 1; IRload = 1; PCwrite = 1; ALU2 = 3'b001;
      OpABLoad = 1; FlagWrite = 1; ALUOutWrite = 1;
      tick();
    end
    reset = 0; #1;
    check_pc("mrst_pc", 8'h00);
    check("mrst_instr", {4'h0, instr}, 8'h00);
    check("mrst_z", {7'd0, Z}, 8'h00);
    check("mrst_opb", mem_addr, 8'h00);
    check("mrst_opa", mem_wdata, 8'h00);
    read_reg("mrst_r1", 1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
